// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Raster timing and test-pattern source for the HDMI/TMDS output path,
//   running in the pixel-clock domain. It generates hsync/vsync/DE for the
//   mode described by the parameters, and an RGB test pattern that can be
//   selected at runtime. Every output is registered, so each output reflects
//   the counter state (h,v) one cycle later.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active high
//   i_mode       pattern: 0 solid, 1 colour bars, 2 checker, 3 scrolling gradient
//   i_color      solid colour {R,G,B} for mode 0
//   o_red/o_green/o_blue  colour channels, forced to 0 outside DE
//   o_enable     DE, high in the active region
//   o_hsync      horizontal sync, asserted level HSYNC_POL
//   o_vsync      vertical sync, asserted level VSYNC_POL
//   o_newline    one-cycle pulse at h==0
//   o_newframe   one-cycle pulse at h==0, v==0
//   o_x, o_y     current h / v count
//   o_frame_cnt  completed-frame counter, wraps modulo 2^16
module video_pattern_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int COLOR_W      = 8,
  parameter int CHECKER_LOG2 = 5,
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW          = $clog2(H_TOTAL),
  localparam int YW          = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_mode,
  input  logic [3*COLOR_W-1:0]   i_color,
  output logic [COLOR_W-1:0]     o_red,
  output logic [COLOR_W-1:0]     o_green,
  output logic [COLOR_W-1:0]     o_blue,
  output logic                   o_enable,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_newline,
  output logic                   o_newframe,
  output logic [XW-1:0]          o_x,
  output logic [YW-1:0]          o_y,
  output logic [15:0]            o_frame_cnt
);

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int BAR_W        = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int PXW          = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [XW-1:0]          h;
  logic [YW-1:0]          v;
  logic [31:0]            hx;
  logic [31:0]            vx;
  logic [15:0]            frame_q;
  logic                   h_last;
  logic                   v_last;
  logic                   at_origin;

  logic [1:0]             mode_q;
  logic [3*COLOR_W-1:0]   color_q;

  logic [2:0]             bar_q;
  logic [PXW-1:0]         px_q;

  logic [1:0]             mode_cur;
  logic [3*COLOR_W-1:0]   color_cur;
  logic [3*COLOR_W-1:0]   rgb;
  logic                   de;
  logic                   hs_act;
  logic                   vs_act;
  logic [31:0]            grad_sum;
  logic [COLOR_W-1:0]     grad;
  logic [COLOR_W-1:0]     chk;

  assign hx        = 32'(h);
  assign vx        = 32'(v);
  assign h_last    = (hx == 32'(H_TOTAL - 1));
  assign v_last    = (vx == 32'(V_TOTAL - 1));
  assign at_origin = (h == '0) && (v == '0);

  // Raster counters; frame counter advances as v wraps so the new value
  // lines up with the (0,0) position it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      h       <= '0;
      v       <= '0;
      frame_q <= '0;
    end else if (h_last) begin
      h <= '0;
      if (v_last) begin
        v       <= '0;
        frame_q <= frame_q + 16'd1;
      end else begin
        v <= v + YW'(1);
      end
    end else begin
      h <= h + XW'(1);
    end
  end

  // Mode and colour are captured only at the frame origin so a change never
  // tears the picture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      color_q <= '0;
    end else if (at_origin) begin
      mode_q  <= i_mode;
      color_q <= i_color;
    end
  end

  // Running bar index that tracks h: steps every BAR_W pixels and saturates at
  // the last bar so it absorbs any remainder of H_ACTIVE/8.
  always_ff @(posedge clk) begin
    if (rst || h_last) begin
      bar_q <= '0;
      px_q  <= '0;
    end else if (px_q == PXW'(BAR_W - 1)) begin
      px_q <= '0;
      if (bar_q != 3'd7) begin
        bar_q <= bar_q + 3'd1;
      end
    end else begin
      px_q <= px_q + PXW'(1);
    end
  end

  always_comb begin
    // The origin pixel must already use the newly sampled mode/colour.
    mode_cur  = at_origin ? i_mode  : mode_q;
    color_cur = at_origin ? i_color : color_q;
    de        = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
    hs_act    = (hx >= 32'(H_SYNC_START)) && (hx < 32'(H_SYNC_END));
    vs_act    = (vx >= 32'(V_SYNC_START)) && (vx < 32'(V_SYNC_END));
    grad_sum  = hx + 32'(frame_q);
    grad      = grad_sum[COLOR_W-1:0];
    chk       = (hx[CHECKER_LOG2] ^ vx[CHECKER_LOG2]) ? '0 : '1;
    rgb       = '0;
    case (mode_cur)
      2'd0:    rgb = color_cur;
      // Bar order white,yellow,cyan,green,magenta,red,blue,black decodes
      // directly from the index bits.
      2'd1:    rgb = {{COLOR_W{~bar_q[1]}}, {COLOR_W{~bar_q[2]}}, {COLOR_W{~bar_q[0]}}};
      2'd2:    rgb = {chk, chk, chk};
      default: rgb = {grad, grad, grad};
    endcase
    if (!de) begin
      rgb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      o_enable    <= 1'b0;
      o_hsync     <= ~HSYNC_POL;
      o_vsync     <= ~VSYNC_POL;
      o_newline   <= 1'b0;
      o_newframe  <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_frame_cnt <= '0;
    end else begin
      o_red       <= rgb[3*COLOR_W-1:2*COLOR_W];
      o_green     <= rgb[2*COLOR_W-1:COLOR_W];
      o_blue      <= rgb[COLOR_W-1:0];
      o_enable    <= de;
      o_hsync     <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      o_vsync     <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      o_newline   <= (h == '0);
      o_newframe  <= at_origin;
      o_x         <= h;
      o_y         <= v;
      o_frame_cnt <= frame_q;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//   Two instances: "a" keeps the default horizontal timing with a short
//   vertical mode (33/1/2/1) so several frames fit in a short run; "b" uses the
//   reduced 8/1/2/1 x 4/1/1/1 mode with inverted sync polarity and random
//   stimulus, and every output of both is compared every cycle.
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        nl;
    logic        nf;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] fc;
  } obs_t;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected registered outputs for raster position index q (cycles since
  // timing restart), from the mode arithmetic alone.
  function automatic obs_t expect_out(input bit rs, input int q, input logic [1:0] mode,
                                      input logic [23:0] col,
                                      input int ha, input int hf, input int hsw, input int hb,
                                      input int va, input int vf, input int vsw, input int vb,
                                      input bit hp, input bit vp, input int cl);
    obs_t e;
    int ht, vt, x, y, bar, g;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    e = '0;
    if (rs) begin
      e.hs = ~hp;
      e.vs = ~vp;
      return e;
    end
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    x    = q % ht;
    y    = (q / ht) % vt;
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.fc = 16'((q / (ht * vt)) % 65536);
    e.de = (x < ha) && (y < va);
    e.hs = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
    e.vs = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
    e.nl = (x == 0);
    e.nf = (x == 0) && (y == 0);
    if (e.de) begin
      case (mode)
        2'd0: e.rgb = col;
        2'd1: begin
          bar = x / (ha / 8);
          if (bar > 7) bar = 7;
          e.rgb = bars[bar];
        end
        2'd2: e.rgb = ((((x >> cl) ^ (y >> cl)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
        default: begin
          g = (x + int'(e.fc)) % 256;
          e.rgb = {3{8'(g)}};
        end
      endcase
    end
    return e;
  endfunction

  // ---------------- instance a ----------------
  localparam int A_HT = 800;
  localparam int A_VT = 37;
  localparam int A_FR = A_HT * A_VT;

  logic        a_rst;
  logic [1:0]  a_mode;
  logic [23:0] a_color;
  logic [7:0]  a_r, a_g, a_b;
  logic        a_en, a_hs, a_vs, a_nl, a_nf;
  logic [9:0]  a_x;
  logic [5:0]  a_y;
  logic [15:0] a_fc;

  video_pattern_gen #(
    .V_ACTIVE(33), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_a (
    .clk(clk), .rst(a_rst), .i_mode(a_mode), .i_color(a_color),
    .o_red(a_r), .o_green(a_g), .o_blue(a_b), .o_enable(a_en),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_newline(a_nl), .o_newframe(a_nf),
    .o_x(a_x), .o_y(a_y), .o_frame_cnt(a_fc)
  );

  // ---------------- instance b ----------------
  localparam int B_FR = 12 * 7;

  logic        b_rst;
  logic [1:0]  b_mode;
  logic [23:0] b_color;
  logic [7:0]  b_r, b_g, b_b;
  logic        b_en, b_hs, b_vs, b_nl, b_nf;
  logic [3:0]  b_x;
  logic [2:0]  b_y;
  logic [15:0] b_fc;

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CHECKER_LOG2(1)
  ) u_b (
    .clk(clk), .rst(b_rst), .i_mode(b_mode), .i_color(b_color),
    .o_red(b_r), .o_green(b_g), .o_blue(b_b), .o_enable(b_en),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_newline(b_nl), .o_newframe(b_nf),
    .o_x(b_x), .o_y(b_y), .o_frame_cnt(b_fc)
  );

  // ---------------- monitor a ----------------
  int          qa = 0;
  logic [1:0]  ma = '0;
  logic [23:0] ca = '0;
  int          lcyc = 0, lde = 0, hsc = 0, hsf = -1, ly = 0, nfc = 0;
  bit          lvalid = 1'b0, nfv = 1'b0;

  always @(posedge clk) begin
    logic        rs;
    logic [1:0]  m;
    logic [23:0] c;
    obs_t        e, o;
    rs = a_rst; m = a_mode; c = a_color;
    #1;
    if (rs) begin
      e  = expect_out(1'b1, 0, 2'd0, 24'h0, 640, 16, 96, 48, 33, 1, 2, 1, 1'b0, 1'b0, 5);
      qa = 0;
    end else begin
      if (qa % A_FR == 0) begin
        ma = m;
        ca = c;
      end
      e  = expect_out(1'b0, qa, ma, ca, 640, 16, 96, 48, 33, 1, 2, 1, 1'b0, 1'b0, 5);
      qa++;
    end
    o = '{rgb: {a_r, a_g, a_b}, de: a_en, hs: a_hs, vs: a_vs, nl: a_nl, nf: a_nf,
          x: 16'(a_x), y: 16'(a_y), fc: a_fc};
    check_val("a_outputs", 128'(o), 128'(e));

    if (!rs) begin
      if (ma == 2'd1 && e.y == 0) begin
        if (e.x == 79)  check_val("bar_x79",  128'(o.rgb), 128'(24'hFFFFFF));
        if (e.x == 80)  check_val("bar_x80",  128'(o.rgb), 128'(24'hFFFF00));
        if (e.x == 639) check_val("bar_x639", 128'(o.rgb), 128'(24'h000000));
        if (e.x == 640) begin
          check_val("bar_x640_rgb", 128'(o.rgb), 128'(24'h000000));
          check_val("bar_x640_de",  128'(o.de),  128'(1'b0));
        end
      end
      if (ma == 2'd2) begin
        if (e.x == 31 && e.y == 0)  check_val("chk_31_0",  128'(o.rgb), 128'(24'hFFFFFF));
        if (e.x == 32 && e.y == 0)  check_val("chk_32_0",  128'(o.rgb), 128'(24'h000000));
        if (e.x == 32 && e.y == 32) check_val("chk_32_32", 128'(o.rgb), 128'(24'hFFFFFF));
        if (e.x == 0  && e.y == 32) check_val("chk_0_32",  128'(o.rgb), 128'(24'h000000));
      end
      if (ma == 2'd3 && e.y == 0 && e.fc == 0) begin
        if (e.x == 0)   check_val("grad_x0",   128'(o.rgb), 128'(24'h000000));
        if (e.x == 255) check_val("grad_x255", 128'(o.rgb), 128'(24'hFFFFFF));
        if (e.x == 256) check_val("grad_x256", 128'(o.rgb), 128'(24'h000000));
      end
    end

    // Per-line and per-frame shape measured from the outputs alone.
    if (rs) begin
      lvalid = 1'b0;
      nfv    = 1'b0;
    end else begin
      if (a_nl) begin
        if (lvalid && lcyc == 800) begin
          check_val("line_de_cnt", 128'(lde), 128'((ly < 33) ? 640 : 0));
          check_val("line_hs_cnt", 128'(hsc), 128'(96));
          check_val("line_hs_x",   128'(hsf), 128'(656));
        end
        lvalid = 1'b1; lcyc = 0; lde = 0; hsc = 0; hsf = -1; ly = int'(a_y);
      end
      if (lvalid) begin
        lcyc++;
        if (a_en) lde++;
        if (!a_hs) begin
          if (hsc == 0) hsf = int'(a_x);
          hsc++;
        end
      end
      if (a_nf) begin
        if (nfv) check_val("frame_period", 128'(nfc), 128'(A_FR));
        nfv = 1'b1;
        nfc = 0;
      end
      if (nfv) nfc++;
    end
  end

  // ---------------- monitor b ----------------
  int          qb = 0;
  logic [1:0]  mb = '0;
  logic [23:0] cb = '0;

  always @(posedge clk) begin
    logic        rs;
    logic [1:0]  m;
    logic [23:0] c;
    obs_t        e, o;
    rs = b_rst; m = b_mode; c = b_color;
    #1;
    if (rs) begin
      e  = expect_out(1'b1, 0, 2'd0, 24'h0, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 1);
      qb = 0;
    end else begin
      if (qb % B_FR == 0) begin
        mb = m;
        cb = c;
      end
      e  = expect_out(1'b0, qb, mb, cb, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 1);
      qb++;
    end
    o = '{rgb: {b_r, b_g, b_b}, de: b_en, hs: b_hs, vs: b_vs, nl: b_nl, nf: b_nf,
          x: 16'(b_x), y: 16'(b_y), fc: b_fc};
    check_val("b_outputs", 128'(o), 128'(e));
  end

  // ---------------- stimulus b ----------------
  initial begin
    int hold;
    int r;
    hold    = 0;
    b_rst   = 1'b1;
    b_mode  = 2'($urandom);
    b_color = 24'($urandom);
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    while (!done) begin
      @(negedge clk);
      r = int'($urandom_range(0, 19999));
      if (hold > 0) hold--;
      else b_rst = 1'b0;
      if (r < 3) begin
        b_rst = 1'b1;
        hold  = int'($urandom_range(0, 3));
      end
      if (r % 37 == 0) b_mode  = 2'($urandom);
      if (r % 53 == 0) b_color = 24'($urandom);
    end
  end

  // ---------------- stimulus a ----------------
  initial begin
    int t;
    a_rst   = 1'b1;
    a_mode  = 2'd0;
    a_color = 24'($urandom);
    repeat (3) @(negedge clk);
    check_val("rst_enable", 128'(a_en), 128'(1'b0));
    check_val("rst_hsync",  128'(a_hs), 128'(1'b1));
    check_val("rst_fc",     128'(a_fc), 128'(16'd0));
    a_rst = 1'b0;
    @(posedge clk); #2;
    check_val("start_newframe", 128'(a_nf), 128'(1'b1));
    check_val("start_enable",   128'(a_en), 128'(1'b1));
    check_val("start_xy",       128'({a_x, a_y}), 128'(16'd0));

    // Frame 0 solid; mode and colour change mid-frame must wait for frame 1.
    t = 10 * A_HT + int'($urandom_range(0, 799));
    repeat (t) @(negedge clk);
    a_mode  = 2'd1;
    a_color = 24'($urandom);
    repeat (A_FR - t + 20 * A_HT) @(negedge clk);

    // Frame 1 bars; reset at line 25 with checker requested.
    a_mode = 2'd2;
    repeat (5 * A_HT) @(negedge clk);
    a_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_fc",    128'(a_fc), 128'(16'd0));
    check_val("midrst_vsync", 128'(a_vs), 128'(1'b1));
    a_rst = 1'b0;
    @(posedge clk); #2;
    check_val("restart_newframe", 128'(a_nf), 128'(1'b1));
    check_val("restart_fc",       128'(a_fc), 128'(16'd0));

    // Checker frame through line 34, then gradient after another reset.
    repeat (34 * A_HT) @(negedge clk);
    a_mode = 2'd3;
    repeat (A_HT) @(negedge clk);
    a_rst = 1'b1;
    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    repeat (2 * A_HT) @(negedge clk);

    done = 1'b1;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
